// File: rtl/arb_mux.sv
// Registered N-bit channel multiplexer with fixed-select or round-robin
// arbitration and a single valid/ready output stage.
module arb_mux #(
    parameter int  N        = 32,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CHANNELS*N-1:0] in_data,
    input  logic [CHANNELS-1:0]   in_valid,
    output logic [CHANNELS-1:0]   in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      control,
    output logic [N-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_channel
);
    localparam int unsigned CH_U = CHANNELS;
    localparam int unsigned N_U  = N;

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] gidx;
    logic             gvalid;
    logic             load;
    logic             xfer;
    logic [N-1:0]     gdata;
    int unsigned      ptr_u;
    int unsigned      ctl_u;
    int unsigned      cand;

    always_comb begin
        gvalid = 1'b0;
        gidx   = '0;
        cand   = 0;
        ptr_u  = {{(32-SEL_W){1'b0}}, ptr};
        ctl_u  = {{(32-SEL_W){1'b0}}, control};
        if (!mode) begin
            if (ctl_u < CH_U) begin
                gvalid = in_valid[control];
                gidx   = control;
            end
        end else begin
            // cyclic search starting just after the last granted channel
            for (int unsigned k = 1; k <= CH_U; k++) begin
                cand = (ptr_u + k) % CH_U;
                if (!gvalid && in_valid[cand[SEL_W-1:0]]) begin
                    gvalid = 1'b1;
                    gidx   = cand[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin
        gdata = '0;
        for (int unsigned i = 0; i < CH_U; i++) begin
            if (gidx == i[SEL_W-1:0])
                gdata = in_data[i*N_U +: N];
        end
    end

    assign load = !out_valid || out_ready;
    assign xfer = load && gvalid;

    // reset gates the strobes so no channel sees an accept while held in reset
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < CH_U; i++)
            in_ready[i] = reset && xfer && (gidx == i[SEL_W-1:0]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            ptr         <= SEL_W'(CHANNELS - 1);
        end else if (xfer) begin
            out_valid   <= 1'b1;
            out_data    <= gdata;
            out_channel <= gidx;
            if (mode)
                ptr <= gidx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_arb_mux;
    localparam int N  = 8;
    localparam int CH = 4;
    localparam int SW = 2;

    localparam int N3  = 4;
    localparam int CH3 = 3;
    localparam int SW3 = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [CH*N-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic            mode;
    logic [SW-1:0]   control;
    logic [N-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_channel;

    logic [CH3*N3-1:0] in_data3;
    logic [CH3-1:0]    in_valid3;
    logic [CH3-1:0]    in_ready3;
    logic              mode3;
    logic [SW3-1:0]    control3;
    logic [N3-1:0]     out_data3;
    logic              out_valid3;
    logic              out_ready3;
    logic [SW3-1:0]    out_channel3;

    arb_mux #(.N(N), .CHANNELS(CH)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .control(control), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel)
    );

    arb_mux #(.N(N3), .CHANNELS(CH3)) dut3 (
        .clock(clock), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .control(control3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_channel(out_channel3)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    // behavioural model state
    logic          m_valid;
    logic [N-1:0]  m_data;
    int            m_ch;
    int            m_ptr;
    int            exp_g;
    logic [CH-1:0] exp_ready;

    function automatic int pick(logic md, logic [SW-1:0] ctl, logic [CH-1:0] v, int ptr);
        int c;
        if (!md) begin
            if (int'(ctl) < CH && v[ctl]) return int'(ctl);
            return -1;
        end
        for (int k = 1; k <= CH; k++) begin
            c = (ptr + k) % CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [CH*N-1:0] rand_data();
        logic [CH*N-1:0] d;
        for (int i = 0; i < CH; i++) d[i*N +: N] = N'($urandom);
        return d;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = CH - 1;
    endtask

    task automatic drive(input logic md, input logic [SW-1:0] ctl, input logic [CH-1:0] v,
                         input logic [CH*N-1:0] d, input logic ordy);
        @(negedge clock);
        mode      = md;
        control   = ctl;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_g     = pick(md, ctl, v, m_ptr);
        exp_ready = '0;
        if (exp_g >= 0 && (!m_valid || ordy)) exp_ready[exp_g] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clock);
        if (!m_valid || out_ready) begin
            if (exp_g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[exp_g*N +: N];
                m_ch    = exp_g;
                if (mode) m_ptr = exp_g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b0;
        in_valid  = '0;
        in_valid3 = '0;
        model_reset();
        #2;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mode = 1'b1; control = '0; in_valid = '1; in_data = rand_data();
        out_ready = 1'b1;
        #3;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
        checks++; if (out_data !== '0) $display("FAIL reset_data got %h want 0", out_data); else passed++;
        checks++; if (out_channel !== '0) $display("FAIL reset_ch got %0d want 0", out_channel); else passed++;
        checks++; if (in_ready !== '0) $display("FAIL reset_ready got %b want 0", in_ready); else passed++;
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_edge_valid got %b want 0", out_valid); else passed++;
        @(negedge clock);
        in_valid = '0;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_fixed();
        logic [CH*N-1:0] d;
        d = rand_data();
        d[2*N +: N] = N'(3);
        drive(1'b0, SW'(2), 4'b0100, d, 1'b1);
        checks++; if (in_ready !== 4'b0100) $display("FAIL fixed_ready got %b want 0100", in_ready); else passed++;
        tick();
        checks++; if (out_data !== N'(3)) $display("FAIL fixed_data got %0d want 3", out_data); else passed++;
        checks++; if (out_channel !== SW'(2)) $display("FAIL fixed_ch got %0d want 2", out_channel); else passed++;
        checks++; if (out_valid !== 1'b1) $display("FAIL fixed_valid got %b want 1", out_valid); else passed++;
    endtask

    task automatic test_round_robin();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, '0, '1, rand_data(), 1'b1);
            checks++; if (in_ready !== CH'(1 << seq[i])) $display("FAIL rr_ready[%0d] got %b want %0d", i, in_ready, seq[i]); else passed++;
            tick();
            checks++; if (out_channel !== SW'(seq[i])) $display("FAIL rr_ch[%0d] got %0d want %0d", i, out_channel, seq[i]); else passed++;
            checks++; if (out_data !== m_data) $display("FAIL rr_data[%0d] got %h want %h", i, out_data, m_data); else passed++;
        end
    endtask

    task automatic test_sparse();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, '0, 4'b1010, rand_data(), 1'b1);
            tick();
            checks++; if (out_channel !== SW'((i % 2) ? 3 : 1)) $display("FAIL sparse_ch[%0d] got %0d want %0d", i, out_channel, (i % 2) ? 3 : 1); else passed++;
        end
    endtask

    task automatic test_stall();
        logic [N-1:0]  hd;
        logic [SW-1:0] hc;
        drive(1'b1, '0, '1, rand_data(), 1'b1);
        tick();
        hd = out_data;
        hc = out_channel;
        checks++; if (hd !== m_data) $display("FAIL stall_pre got %h want %h", hd, m_data); else passed++;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), SW'($urandom), CH'($urandom) | 4'b0001, rand_data(), 1'b0);
            checks++; if (in_ready !== '0) $display("FAIL stall_ready[%0d] got %b want 0", i, in_ready); else passed++;
            tick();
            checks++; if (out_data !== m_data || out_channel !== SW'(m_ch) || out_valid !== 1'b1)
                $display("FAIL stall_hold[%0d] got %h/%0d/%b want %h/%0d/1", i, out_data, out_channel, out_valid, m_data, m_ch);
            else passed++;
        end
        drive(1'b1, '0, '1, rand_data(), 1'b1);
        checks++; if (in_ready !== exp_ready || in_ready === '0) $display("FAIL stall_release_ready got %b want %b", in_ready, exp_ready); else passed++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== m_data || out_channel !== SW'(m_ch))
            $display("FAIL stall_release got %h/%0d/%b want %h/%0d/1", out_data, out_channel, out_valid, m_data, m_ch);
        else passed++;
    endtask

    task automatic test_bad_control();
        @(negedge clock);
        mode3 = 1'b0; control3 = SW3'(1); in_valid3 = '1; in_data3 = 12'h5A3; out_ready3 = 1'b1;
        #1;
        checks++; if (in_ready3 !== 3'b010) $display("FAIL bad_ready_ok got %b want 010", in_ready3); else passed++;
        @(posedge clock); #1;
        checks++; if (out_valid3 !== 1'b1 || out_data3 !== 4'hA || out_channel3 !== SW3'(1))
            $display("FAIL bad_load got %h/%0d/%b want a/1/1", out_data3, out_channel3, out_valid3);
        else passed++;
        @(negedge clock);
        control3 = SW3'(3);
        #1;
        checks++; if (in_ready3 !== '0) $display("FAIL bad_ready got %b want 000", in_ready3); else passed++;
        @(posedge clock); #1;
        checks++; if (out_valid3 !== 1'b0) $display("FAIL bad_drop got %b want 0", out_valid3); else passed++;
        checks++; if (out_data3 !== 4'hA || out_channel3 !== SW3'(1)) $display("FAIL bad_hold got %h/%0d want a/1", out_data3, out_channel3); else passed++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, '0, '1, rand_data(), 1'b1);
        tick();
        checks++; if (out_valid !== 1'b1) $display("FAIL areset_pre got %b want 1", out_valid); else passed++;
        #2;
        reset    = 1'b0;
        in_valid = '0;
        model_reset();
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_channel !== '0)
            $display("FAIL areset_clear got %h/%0d/%b want 0/0/0", out_data, out_channel, out_valid);
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, '0, '1, rand_data(), 1'b1);
        tick();
        checks++; if (out_channel !== '0 || out_valid !== 1'b1) $display("FAIL areset_restart got %0d/%b want 0/1", out_channel, out_valid); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), SW'($urandom), CH'($urandom), rand_data(), ($urandom % 4) != 0);
            checks++; if (in_ready !== exp_ready) $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready, exp_ready); else passed++;
            tick();
            checks++; if (out_valid !== m_valid || out_data !== m_data || out_channel !== SW'(m_ch))
                $display("FAIL rand_out[%0d] got %h/%0d/%b want %h/%0d/%b", i, out_data, out_channel, out_valid, m_data, m_ch, m_valid);
            else passed++;
        end
    endtask

    initial begin
        in_valid3 = '0; in_data3 = '0; mode3 = 1'b0; control3 = '0; out_ready3 = 1'b1;
        exp_g = -1;
        exp_ready = '0;
        model_reset();
        test_reset();
        test_fixed();
        test_round_robin();
        test_sparse();
        test_stall();
        test_bad_control();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
